// File: rtl/modexp_scheduler_pkg.sv
// Shared types for the modexp scheduler: FSM state and operation encodings.
// No logic; no latency or backpressure of its own.
package modexp_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic OP_ENC = 1'b1;
  localparam logic OP_DEC = 1'b0;

endpackage

// File: rtl/modexp_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves on grant.
// Zero latency; no grant while i_en is low.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Port granted most recently; reset to 1 so port 0 wins the first contest.
  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_gnt = r_last ? 2'b01 : 2'b10;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (o_gnt != 2'b00) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/modexp_scheduler.sv
// Schedules two requesters onto one external modexp engine: grant, load, wait, respond.
// Grant to rsp_valid = engine cycles + 2; response held until rspX_ready, no new grant meanwhile.
module modexp_scheduler
  import modexp_scheduler_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [2*WIDTH-1:0] key_n,
  input  logic [2*WIDTH-1:0] key_e,
  input  logic [2*WIDTH-1:0] key_d,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_msg,
  input  logic               req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_msg,
  input  logic               req1_op,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [2*WIDTH-1:0] rsp0_data,
  output logic               rsp0_err,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp1_data,
  output logic               rsp1_err,
  output logic [2*WIDTH-1:0] eng_base,
  output logic [2*WIDTH-1:0] eng_modulo,
  output logic [2*WIDTH-1:0] eng_exponent,
  output logic               eng_load,
  input  logic               eng_finish,
  input  logic [2*WIDTH-1:0] eng_result,
  output logic               busy
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_port;
  logic [DW-1:0]   r_base;
  logic [DW-1:0]   r_mod;
  logic [DW-1:0]   r_exp;
  logic [DW-1:0]   r_data;
  logic            r_err;
  logic [1:0]      w_gnt;
  logic            w_arb_en;
  logic            w_timeout;
  logic            w_rsp_take;
  logic [WIDTH-1:0] w_msg;
  logic            w_op;

  assign w_arb_en = reset && (r_state == IDLE) && key_valid;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_arb_en),
    .i_req ({req1_valid, req0_valid}),
    .o_gnt (w_gnt)
  );

  assign w_msg      = w_gnt[1] ? req1_msg : req0_msg;
  assign w_op       = w_gnt[1] ? req1_op  : req0_op;
  assign w_timeout  = (r_cnt >= CW'(TIMEOUT - 1));
  assign w_rsp_take = r_port ? rsp1_ready : rsp0_ready;

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    eng_load    = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_gnt[0];
        req1_ready = w_gnt[1];
        if (w_gnt != 2'b00) w_state_nxt = LOAD;
      end
      LOAD: begin
        // Suppressed while reset is low so a reset landing in LOAD never loads the engine.
        eng_load    = reset;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_finish || w_timeout) w_state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~r_port;
        rsp1_valid = r_port;
        if (w_rsp_take) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_port  <= 1'b0;
      r_base  <= '0;
      r_mod   <= '0;
      r_exp   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_gnt != 2'b00) begin
            r_port <= w_gnt[1];
            r_base <= {{WIDTH{1'b0}}, w_msg};
            r_mod  <= key_n;
            r_exp  <= (w_op == OP_ENC) ? key_e : key_d;
          end
        end
        LOAD: r_cnt <= '0;
        WAIT: begin
          // A finish in the last allowed cycle still wins over the timeout.
          if (eng_finish) begin
            r_data <= eng_result;
            r_err  <= 1'b0;
          end else if (w_timeout) begin
            r_data <= '0;
            r_err  <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign eng_base     = r_base;
  assign eng_modulo   = r_mod;
  assign eng_exponent = r_exp;
  assign rsp0_data    = r_data;
  assign rsp1_data    = r_data;
  assign rsp0_err     = r_err;
  assign rsp1_err     = r_err;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_modexp_scheduler.sv
// Scoreboard bench for modexp_scheduler with a latency-programmable stub engine.
`timescale 1ns/1ps
module tb_modexp_scheduler;

  localparam int WIDTH = 32;
  localparam int DW    = 64;
  localparam int TO    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, key_valid;
  logic [DW-1:0] key_n, key_e, key_d;
  logic          req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
  logic [31:0]   req0_msg, req1_msg;
  logic          rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [DW-1:0] eng_base, eng_modulo, eng_exponent, eng_result;
  logic          eng_load, eng_finish, busy;

  modexp_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid),
    .key_n(key_n), .key_e(key_e), .key_d(key_d),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_msg(req0_msg), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_msg(req1_msg), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .eng_base(eng_base), .eng_modulo(eng_modulo), .eng_exponent(eng_exponent),
    .eng_load(eng_load), .eng_finish(eng_finish), .eng_result(eng_result), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stub engine: finish rises in the eng_lat-th cycle after load and stays high (stale) until the next load.
  function automatic logic [DW-1:0] modexp(input logic [DW-1:0] b, input logic [DW-1:0] e,
                                           input logic [DW-1:0] m);
    logic [127:0] r, x, mm;
    mm = {64'd0, m};
    r  = 128'd1;
    x  = {64'd0, b} % mm;
    for (int i = 0; i < DW; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[DW-1:0];
  endfunction

  int            eng_lat = 3;
  bit            eng_hang = 1'b0;
  int            e_cnt = 0;
  bit            e_run = 1'b0;
  bit            e_hang_l = 1'b0;
  logic [DW-1:0] e_res = '0;

  always @(posedge clk) begin
    if (eng_load) begin
      e_cnt    <= eng_lat - 1;
      e_run    <= 1'b1;
      e_hang_l <= eng_hang;
      e_res    <= modexp(eng_base, eng_exponent, eng_modulo);
    end else if (e_run && e_cnt > 0) begin
      e_cnt <= e_cnt - 1;
    end
  end
  assign eng_finish = e_run && (e_cnt == 0) && !e_hang_l;
  assign eng_result = e_res;

  // Scoreboard
  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          err;
    int            lat;
    int            hold;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_port_q[$];
  int   gnt_cyc_q[$];
  int   gnt_total = 0;
  int   held = 0;

  task automatic push_exp(input int port, input logic [DW-1:0] data, input logic err,
                          input int lat, input int hold);
    exp_t e;
    e.port = port; e.data = data; e.err = err; e.lat = lat; e.hold = hold;
    exp_q.push_back(e);
  endtask

  // Grant monitor
  always @(negedge clk) begin
    if (!key_valid || !reset) chk("ready_gated", {62'd0, req1_ready, req0_ready}, 64'd0);
    if (req0_ready && req1_ready) chk("one_hot_grant", 64'd3, 64'd1);
    if (req0_ready || req1_ready) begin
      gnt_port_q.push_back(req1_ready ? 1 : 0);
      gnt_cyc_q.push_back(cyc);
      gnt_total++;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    int   rp;
    if (reset && (rsp0_valid || rsp1_valid)) begin
      if (exp_q.size() == 0 || gnt_cyc_q.size() == 0) begin
        chk("unexpected_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        rsp0_ready = rsp0_valid;
        rsp1_ready = rsp1_valid;
      end else begin
        e  = exp_q[0];
        rp = rsp1_valid ? 1 : 0;
        chk("rsp_only_granted", {62'd0, rsp1_valid, rsp0_valid}, (e.port == 1) ? 64'd2 : 64'd1);
        chk("rsp_data", rp ? rsp1_data : rsp0_data, e.data);
        chk("rsp_err", {63'd0, rp ? rsp1_err : rsp0_err}, {63'd0, e.err});
        if (held == 0) begin
          chk("grant_port", gnt_port_q[0], e.port);
          chk("latency", cyc - gnt_cyc_q[0], e.lat);
        end
        if (held >= e.hold) begin
          rsp0_ready = (rp == 0);
          rsp1_ready = (rp == 1);
          void'(exp_q.pop_front());
          void'(gnt_port_q.pop_front());
          void'(gnt_cyc_q.pop_front());
          held = 0;
        end else begin
          held++;
        end
      end
    end else begin
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
    end
  end

  // Driver helpers
  task automatic wait_grant(input int port, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((port == 0) ? req0_ready : req1_ready) && n < 60);
    if (n >= 60) chk("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input int port, input logic [31:0] msg, input logic op);
    int n;
    @(posedge clk); #1;
    if (port == 0) begin req0_valid = 1'b1; req0_msg = msg; req0_op = op; end
    else           begin req1_valid = 1'b1; req1_msg = msg; req1_op = op; end
    wait_grant(port, n);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_eng_load"}, {63'd0, eng_load}, 64'd0);
    chk({tag, "_req_ready"}, {62'd0, req1_ready, req0_ready}, 64'd0);
    chk({tag, "_rsp_valid"}, {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    chk({tag, "_rsp_err"}, {62'd0, rsp1_err, rsp0_err}, 64'd0);
    chk({tag, "_rsp_data"}, rsp0_data | rsp1_data, 64'd0);
    chk({tag, "_eng_ops"}, eng_base | eng_modulo | eng_exponent, 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0; key_valid = 1'b1;
    key_n = 64'd3233; key_e = 64'd17; key_d = 64'd2753;
    req0_valid = 1'b1; req0_msg = 32'd65; req0_op = 1'b1;
    req1_valid = 1'b0; req1_msg = 32'd0;  req1_op = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset with a request already pending: nothing granted until release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");

    // Encrypt, port 0: 65^17 mod 3233 = 2790
    eng_lat = 3;
    push_exp(0, 64'd2790, 1'b0, 5, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_grant(0, n);
    chk("first_grant_after_release", n, 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();

    // Engine finishing in the last allowed cycle still succeeds.
    eng_lat = TO;
    push_exp(0, 64'd2790, 1'b0, TO + 2, 0);
    issue(0, 32'd65, 1'b1);
    drain();

    // Decrypt, port 1, one-cycle engine: 2790^2753 mod 3233 = 65
    eng_lat = 1;
    push_exp(1, 64'd65, 1'b0, 3, 0);
    issue(1, 32'd2790, 1'b0);
    drain();

    // Both ports valid for four jobs: alternate 0,1,0,1.
    eng_lat = 2;
    push_exp(0, 64'd2790, 1'b0, 4, 0);
    push_exp(1, 64'd65,   1'b0, 4, 0);
    push_exp(0, 64'd2790, 1'b0, 4, 0);
    push_exp(1, 64'd65,   1'b0, 4, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_msg = 32'd65;   req0_op = 1'b1;
    req1_valid = 1'b1; req1_msg = 32'd2790; req1_op = 1'b0;
    n = gnt_total;
    for (int i = 0; i < 200 && gnt_total < n + 4; i++) @(negedge clk);
    chk("rr_four_grants", gnt_total - n, 64'd4);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // key_valid low holds the request off; grant follows as soon as it rises.
    eng_lat = 3;
    key_valid = 1'b0;
    req0_valid = 1'b1; req0_msg = 32'd65; req0_op = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    key_valid = 1'b1;
    push_exp(0, 64'd2790, 1'b0, 5, 0);
    wait_grant(0, n);
    chk("grant_after_key_valid", n, 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();

    // Engine hangs: timeout error after TIMEOUT+2, response held 4 cycles.
    eng_hang = 1'b1;
    push_exp(0, 64'd0, 1'b1, TO + 2, 3);
    issue(0, 32'd65, 1'b1);
    drain();

    // Reset in WAIT abandons the job silently.
    issue(0, 32'd65, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_before_reset", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("eng_load_in_reset", {63'd0, eng_load}, 64'd0);
    end
    chk_reset_state("mid_reset");
    gnt_port_q.delete();
    gnt_cyc_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    eng_hang = 1'b0;
    eng_lat = 4;
    push_exp(0, 64'd2790, 1'b0, 6, 0);
    issue(0, 32'd65, 1'b1);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("idle_at_end", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
